// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode, flag-index and flag-type definitions for alu_pipe
//
// Purpose : Opcode encodings, the bit positions of the status flags, and a
//           packed flags type that both the ALU core and the pipe use.
// Contents: OP_NAND..OP_MUL (4-bit opcodes), FLAG_Z/N/C/V bit indices,
//           flags_t = {overflow, carry, negative, zero}.
package alu_pipe_pkg;

  localparam logic [3:0] OP_NAND = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SRA  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_NOTA = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_AND  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational ALU datapath for alu_pipe
//
// Purpose : Computes result, status flags and the illegal-opcode indication
//           for one operand pair. Purely combinational; the pipe registers it.
// Macro   : ALU_MUL_EN - when defined, opcode 12 is an unsigned multiply;
//           otherwise opcode 12 is illegal and no multiplier exists.
// Ports   : a_i, b_i      WIDTH  operands (b_i is also the shift amount)
//           opcode_i      4      operation select
//           result_o      WIDTH  result
//           flags_o       4      {overflow, carry, negative, zero}
//           illegal_o     1      opcode unsupported
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       opcode_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o,
  output logic             illegal_o
);

  localparam int MSB   = WIDTH - 1;
  // Wide enough to hold both b_i and the constant WIDTH without truncation.
  localparam int EXT_W = WIDTH + 32;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_shift_big;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [3:0]       w_flags;

  assign w_sum       = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the extended difference is the unsigned borrow.
  assign w_diff      = {1'b0, a_i} - {1'b0, b_i};
  assign w_shift_big = (EXT_W'(b_i) >= EXT_W'(WIDTH));

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (opcode_i)
      OP_NAND: w_res = ~(a_i & b_i);
      OP_XOR:  w_res = a_i ^ b_i;
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a_i[MSB] == b_i[MSB]) && (w_sum[MSB] != a_i[MSB]);
      end
      OP_SRA:  w_res = w_shift_big ? {WIDTH{a_i[MSB]}} : WIDTH'($signed(a_i) >>> b_i);
      OP_OR:   w_res = a_i | b_i;
      OP_SLL:  w_res = w_shift_big ? '0 : (a_i << b_i);
      OP_NOTA: w_res = ~a_i;
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a_i[MSB] != b_i[MSB]) && (w_diff[MSB] != a_i[MSB]);
      end
      OP_SRL:  w_res = w_shift_big ? '0 : (a_i >> b_i);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_AND:  w_res = a_i & b_i;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        w_res = w_prod[MSB:0];
        w_c   = |w_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal ops leave w_res at 0, so zero=1 falls out naturally.
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_N] = w_res[MSB];
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

  assign result_o  = w_res;
  assign flags_o   = flags_t'(w_flags);
  assign illegal_o = w_ill;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with valid/ready handshake on both sides
//
// Purpose : Stage 1 computes via alu_pipe_core; stages 2..STAGES only
//           register. Back-pressure from ready_i stalls the chain without
//           dropping ops; completed outputs are counted.
// Macro   : ALU_MUL_EN (consumed by alu_pipe_core) enables opcode 12 MUL.
// Ports   : clk_i, rst_i (async, active-high)
//           valid_i/ready_o, first_i, second_i, opcode_i   input side
//           valid_o/ready_i, result_o, flags_o, illegal_o  output side
//           op_count_o  CNT_W  number of output transfers (wraps)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] second_i,
  input  logic [3:0]       opcode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] op_count_o
);

  logic [WIDTH-1:0]  w_core_result;
  flags_t            w_core_flags;
  logic              w_core_illegal;
  logic [STAGES-1:0] w_load;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_result [STAGES];
  flags_t            r_flags  [STAGES];
  logic [STAGES-1:0] r_illegal;
  logic [CNT_W-1:0]  r_op_count;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (first_i),
    .b_i      (second_i),
    .opcode_i (opcode_i),
    .result_o (w_core_result),
    .flags_o  (w_core_flags),
    .illegal_o(w_core_illegal)
  );

  // Stage k loads unless it and every stage after it are occupied while the
  // consumer is stalled; this is the unrolled form of "empty or next loads".
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign w_load[k] = ready_i || !(&r_valid[STAGES-1:k]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= '0;
      r_illegal  <= '0;
      r_op_count <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_result[k] <= '0;
        r_flags[k]  <= '0;
      end
    end else begin
      // Data registers only capture real ops; bubbles keep the old contents.
      if (w_load[0]) begin
        r_valid[0] <= valid_i;
        if (valid_i) begin
          r_result[0]  <= w_core_result;
          r_flags[0]   <= w_core_flags;
          r_illegal[0] <= w_core_illegal;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_result[k]  <= r_result[k-1];
            r_flags[k]   <= r_flags[k-1];
            r_illegal[k] <= r_illegal[k-1];
          end
        end
      end
      if (r_valid[STAGES-1] && ready_i) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign ready_o    = w_load[0];
  assign valid_o    = r_valid[STAGES-1];
  assign result_o   = r_result[STAGES-1];
  assign flags_o    = r_flags[STAGES-1];
  assign illegal_o  = r_illegal[STAGES-1];
  assign op_count_o = r_op_count;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking randomized bench for alu_pipe
module tb_alu_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] first_i = '0;
  logic [WIDTH-1:0] second_i = '0;
  logic [3:0]       opcode_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] result_o;
  logic [3:0]       flags_o;
  logic             illegal_o;
  logic [CNT_W-1:0] op_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [12:0] exp_q[$];
  logic        acc;
  logic        prev_hold = 1'b0;
  logic [13:0] prev_out;
  logic        seen_low;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .first_i   (first_i),
    .second_i  (second_i),
    .opcode_i  (opcode_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .flags_o   (flags_o),
    .illegal_o (illegal_o),
    .op_count_o(op_count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {illegal, V, C, N, Z, result} computed with integer arithmetic.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8);
    int a, b, sa, sb, r, full;
    logic c, v, ill;
    a = int'(a8); b = int'(b8);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0; ill = 0; full = 0;
    case (op)
      4'd0:  r = 255 - (a & b);
      4'd1:  r = a ^ b;
      4'd2:  begin full = a + b; r = full % 256; c = (full > 255);
                   v = (sa + sb > 127) || (sa + sb < -128); end
      4'd3:  r = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      4'd4:  r = a | b;
      4'd5:  r = (b >= 8) ? 0 : ((a << b) & 255);
      4'd6:  r = 255 - a;
      4'd7:  r = (a < b) ? 1 : 0;
      4'd8:  begin r = (a - b + 256) % 256; c = (a < b);
                   v = (sa - sb > 127) || (sa - sb < -128); end
      4'd9:  r = (b >= 8) ? 0 : (a >> b);
      4'd10: r = (sa < sb) ? 1 : 0;
      4'd11: r = a & b;
`ifdef ALU_MUL_EN
      4'd12: begin full = a * b; r = full % 256; c = (full > 255); end
`endif
      default: ill = 1;
    endcase
    return {ill, v, c, (r >= 128), (r == 0), r[7:0]};
  endfunction

  // One clock: sample handshakes at the falling edge, then return 1 after the rising edge.
  task automatic step();
    logic [12:0] e;
    @(negedge clk);
    acc = valid_i && ready_o;
    if (ready_i) check("ready_passthru", ready_o, 1);
    if (prev_hold) check("hold_stable", {valid_o, illegal_o, flags_o, result_o}, prev_out);
    if (valid_o && ready_i) begin
      check("out_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", {illegal_o, flags_o, result_o}, e);
      end
      exp_cnt++;
    end
    if (acc) exp_q.push_back(model(opcode_i, first_i, second_i));
    prev_hold = valid_o && !ready_i;
    prev_out  = {valid_o, illegal_o, flags_o, result_o};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    prev_hold = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [12:0] exp);
    valid_i = 1'b1; opcode_i = op; first_i = a; second_i = b; ready_i = 1'b1;
    step();
    check({tag, "_acc"}, acc, 1);
    valid_i = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      check({tag, "_early"}, valid_o, 0);
      step();
    end
    check({tag, "_valid"}, valid_o, 1);
    check(tag, {illegal_o, flags_o, result_o}, exp);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent, cyc, seen;
    do_reset();
    check("rst_valid", valid_o, 0);
    check("rst_outs", {illegal_o, flags_o, result_o}, 0);
    check("rst_count", op_count_o, 0);

    // Flags packed as {V,C,N,Z}.
    directed("add_ff_01", 4'd2, 8'hFF, 8'h01, {1'b0, 4'b0101, 8'h00});
    check("count_after_add", op_count_o, 1);
    directed("sub_80_01", 4'd8, 8'h80, 8'h01, {1'b0, 4'b1000, 8'h7F});
    directed("slt_ff_01", 4'd10, 8'hFF, 8'h01, {1'b0, 4'b0000, 8'h01});
    directed("sltu_ff_01", 4'd7, 8'hFF, 8'h01, {1'b0, 4'b0001, 8'h00});
    directed("sra_90_9", 4'd3, 8'h90, 8'd9, {1'b0, 4'b0010, 8'hFF});
    directed("sll_01_8", 4'd5, 8'h01, 8'd8, {1'b0, 4'b0001, 8'h00});
    directed("srl_80_7", 4'd9, 8'h80, 8'd7, {1'b0, 4'b0000, 8'h01});
    directed("illegal_14", 4'd14, 8'h5A, 8'h33, {1'b1, 4'b0001, 8'h00});
`ifdef ALU_MUL_EN
    directed("mul_10_10", 4'd12, 8'h10, 8'h10, {1'b0, 4'b0101, 8'h00});
`else
    directed("op12_illegal", 4'd12, 8'h10, 8'h10, {1'b1, 4'b0001, 8'h00});
`endif
    check("count_directed", op_count_o, 9);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      valid_i  = ($urandom_range(0, 3) != 0);
      opcode_i = 4'($urandom_range(0, 15));
      first_i  = 8'($urandom);
      second_i = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      ready_i  = ($urandom_range(0, 3) != 0);
      step();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("rand_drained", exp_q.size(), 0);
    check("rand_count", op_count_o, 16'(exp_cnt));

    // Six back-to-back ADDs with the consumer stalled for three cycles.
    do_reset();
    sent = 0; cyc = 0; seen_low = 1'b0;
    while (sent < 6 && cyc < 50) begin
      valid_i  = 1'b1;
      opcode_i = 4'd2;
      first_i  = 8'(sent * 37 + 11);
      second_i = 8'(sent * 5 + 200);
      ready_i  = (cyc >= 2 && cyc < 5) ? 1'b0 : 1'b1;
      #1;
      if (!ready_o) seen_low = 1'b1;
      step();
      if (acc) sent++;
      cyc++;
    end
    check("stall_sent", sent, 6);
    check("stall_ready_drop", seen_low, 1);
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("stall_drained", exp_q.size(), 0);
    check("stall_count", op_count_o, 6);

    // Asynchronous reset with two ops in flight.
    ready_i = 1'b0; valid_i = 1'b1; opcode_i = 4'd2; first_i = 8'd3; second_i = 8'd4;
    step();
    first_i = 8'd5; second_i = 8'd6;
    step();
    valid_i = 1'b0;
    check("inflight_valid", valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_outs", {illegal_o, flags_o, result_o}, 0);
    check("arst_count", op_count_o, 0);
    rst_i = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    prev_hold = 1'b0;
    ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid_o) seen++;
      step();
    end
    check("arst_no_stale", seen, 0);
    check("arst_count_after", op_count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
